// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache between the datapath fetch port
// and the memory arbiter, with saturating hit/miss statistics.
module icache_responder #(
    parameter int SETS  = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             inval,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } line_t;

    state_t            state, state_n;
    logic [SETS-1:0]   valid;
    line_t             lines [SETS];
    logic [29:0]       miss_word;

    logic [IDX_W-1:0]  req_idx, fill_idx;
    logic [TAG_W-1:0]  req_tag, fill_tag;
    logic              hit, miss_start, fill;
    logic              unused_bits;

    assign req_idx     = imemaddr[IDX_W+1:2];
    assign req_tag     = imemaddr[31:IDX_W+2];
    assign fill_idx    = miss_word[IDX_W-1:0];
    assign fill_tag    = miss_word[29:IDX_W];
    assign unused_bits = ^imemaddr[1:0];

    // Hits are only served in IDLE so a fill never races a lookup.
    assign hit      = (state == IDLE) && imemREN && valid[req_idx] &&
                      (lines[req_idx].tag == req_tag);
    assign ihit     = hit;
    assign imemload = hit ? lines[req_idx].data : 32'h0;

    always_comb begin
        state_n    = state;
        miss_start = 1'b0;
        fill       = 1'b0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        case (state)
            IDLE: begin
                if (imemREN && !hit) begin
                    miss_start = 1'b1;
                    state_n    = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word, 2'b00};
                if (!iwait) begin
                    fill    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_word <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            state <= state_n;
            if (miss_start)
                miss_word <= imemaddr[31:2];
            // inval takes priority so a fill landing in the same cycle is dropped.
            if (inval)
                valid <= '0;
            else if (fill)
                valid[fill_idx] <= 1'b1;
            if (hit && (hit_cnt != {CNT_W{1'b1}}))
                hit_cnt <= hit_cnt + 1'b1;
            if (miss_start && (miss_cnt != {CNT_W{1'b1}}))
                miss_cnt <= miss_cnt + 1'b1;
        end
    end

    // Tag/data need no reset; valid alone gates their use.
    always_ff @(posedge CLK) begin
        if (fill)
            lines[fill_idx] <= '{tag: fill_tag, data: iload};
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: memory is modelled inline by the miss task,
// expected hit data flows through a scoreboard queue.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        RST, imemREN, inval, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;
    logic [3:0]  hit_cnt, miss_cnt;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] sb [$];

    icache_responder #(.SETS(16), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inval(inval), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; imemREN = 1'b0; inval = 1'b0; iwait = 1'b1; iload = 32'h0;
        cyc();
        RST = 1'b0;
    endtask

    // Request that must miss; memory holds iwait for lat cycles, then returns d.
    task automatic miss(input logic [31:0] a, input logic [31:0] d, input int lat,
                        input bit inv_last);
        int nren = 0;
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        #1;
        chk("miss_nohit", {31'h0, ihit}, 32'h0);
        chk("miss_idle_iren", {31'h0, iREN}, 32'h0);
        cyc();
        for (int i = 0; i <= lat; i++) begin
            iwait = (i < lat);
            iload = (i == lat) ? d : 32'h0;
            inval = (i == lat) && inv_last;
            #1;
            if (iREN) nren++;
            chk("miss_iaddr", iaddr, {a[31:2], 2'b00});
            chk("fetch_nohit", {31'h0, ihit}, 32'h0);
            cyc();
        end
        inval = 1'b0; iwait = 1'b1;
        chk("miss_iren_cycles", nren, lat + 1);
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp;
        imemREN = 1'b1; imemaddr = a;
        sb.push_back(d);
        #1;
        chk("hit_ihit", {31'h0, ihit}, 32'h1);
        chk("hit_iren", {31'h0, iREN}, 32'h0);
        exp = sb.pop_front();
        if (ihit) chk("hit_data", imemload, exp);
        cyc();
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; inval = 1'b0;
        iwait = 1'b1; iload = 32'h0;
        cyc(); cyc();
        RST = 1'b0;
        #1;
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iren", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_hitcnt", {28'h0, hit_cnt}, 32'h0);
        chk("rst_misscnt", {28'h0, miss_cnt}, 32'h0);
        cyc();

        // cold miss + repeat hits
        miss(32'h0, 32'h2001_0005, 3, 1'b0);
        chk("cold_misscnt", {28'h0, miss_cnt}, 32'h1);
        for (int i = 0; i < 5; i++) hit(32'h0, 32'h2001_0005);
        imemREN = 1'b0;
        #1;
        chk("repeat_hitcnt", {28'h0, hit_cnt}, 32'h5);
        cyc();

        // conflict eviction on index 0
        miss(32'h40, 32'hDEAD_BEEF, 1, 1'b0);
        hit(32'h40, 32'hDEAD_BEEF);
        miss(32'h0, 32'h2001_0005, 2, 1'b0);
        hit(32'h0, 32'h2001_0005);
        chk("conflict_misscnt", {28'h0, miss_cnt}, 32'h3);

        // invalidate all, then invalidate on fill completion
        miss(32'h4, 32'h1111_0004, 1, 1'b0);
        miss(32'h8, 32'h1111_0008, 0, 1'b0);
        hit(32'h4, 32'h1111_0004);
        hit(32'h8, 32'h1111_0008);
        imemREN = 1'b0; inval = 1'b1;
        cyc();
        inval = 1'b0;
        miss(32'h4, 32'h1111_0004, 1, 1'b0);
        hit(32'h4, 32'h1111_0004);
        miss(32'hC, 32'h1111_000C, 2, 1'b1);
        miss(32'hC, 32'h2222_000C, 1, 1'b0);
        hit(32'hC, 32'h2222_000C);

        // reset in the middle of a fetch
        miss(32'h10, 32'h3333_0010, 0, 1'b0);
        hit(32'h10, 32'h3333_0010);
        imemREN = 1'b1; imemaddr = 32'h20; iwait = 1'b1;
        cyc();
        #1;
        chk("midfetch_iren", {31'h0, iREN}, 32'h1);
        RST = 1'b1;
        cyc();
        RST = 1'b0; imemREN = 1'b0;
        #1;
        chk("postrst_iren", {31'h0, iREN}, 32'h0);
        chk("postrst_ihit", {31'h0, ihit}, 32'h0);
        chk("postrst_hitcnt", {28'h0, hit_cnt}, 32'h0);
        chk("postrst_misscnt", {28'h0, miss_cnt}, 32'h0);
        cyc();
        miss(32'h10, 32'h3333_0010, 1, 1'b0);
        hit(32'h10, 32'h3333_0010);

        // request dropped during fetch, then hit counter saturation
        do_reset();
        imemREN = 1'b1; imemaddr = 32'h24; iwait = 1'b1;
        cyc();
        imemREN = 1'b0; imemaddr = 32'h100;
        #1;
        chk("drop_iren0", {31'h0, iREN}, 32'h1);
        cyc();
        iwait = 1'b0; iload = 32'h1234_5678;
        #1;
        chk("drop_iren1", {31'h0, iREN}, 32'h1);
        chk("drop_iaddr", iaddr, 32'h24);
        cyc();
        iwait = 1'b1;
        hit(32'h24, 32'h1234_5678);
        hit(32'h27, 32'h1234_5678);
        for (int i = 0; i < 18; i++) hit(32'h24, 32'h1234_5678);
        imemREN = 1'b0;
        #1;
        chk("sat_hitcnt", {28'h0, hit_cnt}, 32'hF);
        chk("sat_misscnt", {28'h0, miss_cnt}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
